// File: rtl/acoustic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : acoustic_pkg                                                  |
// | Purpose  : Shared constants and FSM state type for the acoustic level    |
// |            meter slice.                                                  |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package acoustic_pkg;

   localparam int ADC_WIDTH = 12;
   localparam int MIDSCALE  = 2048;
   localparam int LED_WIDTH = 7;
   localparam int LED_STEP  = 256;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

endpackage : acoustic_pkg
`default_nettype wire

// File: rtl/acoustic_level_meter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : acoustic_level_meter_if                                       |
// | Purpose  : Sample input and level/detect output bundle of the meter.     |
// | Ports    : master drives SAMPLE, SAMPLE_VALID, THRESHOLD and observes    |
// |            LEVEL, PEAK, LEVEL_VALID, DETECT, LED; slave is the meter.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface acoustic_level_meter_if;
   import acoustic_pkg::*;

   logic [ADC_WIDTH-1:0] SAMPLE;
   logic                 SAMPLE_VALID;
   logic [ADC_WIDTH-1:0] THRESHOLD;
   logic [ADC_WIDTH-1:0] LEVEL;
   logic [ADC_WIDTH-1:0] PEAK;
   logic                 LEVEL_VALID;
   logic                 DETECT;
   logic [LED_WIDTH-1:0] LED;

   modport master (
      output SAMPLE, SAMPLE_VALID, THRESHOLD,
      input  LEVEL, PEAK, LEVEL_VALID, DETECT, LED
   );

   modport slave (
      input  SAMPLE, SAMPLE_VALID, THRESHOLD,
      output LEVEL, PEAK, LEVEL_VALID, DETECT, LED
   );

endinterface : acoustic_level_meter_if
`default_nettype wire

// File: rtl/adc_magnitude.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adc_magnitude                                                 |
// | Purpose  : Converts an offset-binary ADC sample to |SAMPLE - midscale|   |
// |            and registers it together with its valid flag (stage 1).     |
// | Ports    : CLOCK, RESET      - clock, synchronous active-high reset      |
// |            sample_i/_valid_i - raw ADC sample and qualifier              |
// |            mag_o/mag_valid_o - registered magnitude 0..2048 and valid    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module adc_magnitude
   import acoustic_pkg::*;
(
   input  wire logic                 CLOCK,
   input  wire logic                 RESET,
   input  wire logic [ADC_WIDTH-1:0] sample_i,
   input  wire logic                 sample_valid_i,
   output logic      [ADC_WIDTH-1:0] mag_o,
   output logic                      mag_valid_o
);

   localparam logic [ADC_WIDTH-1:0] c_MID = ADC_WIDTH'(MIDSCALE);

   logic [ADC_WIDTH-1:0] w_mag;
   logic [ADC_WIDTH-1:0] mag_q;
   logic                 valid_q;

   // Sample 0 gives 2048, which still fits in 12 unsigned bits.
   assign w_mag = (sample_i >= c_MID) ? (sample_i - c_MID) : (c_MID - sample_i);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         mag_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         mag_q   <= w_mag;
         valid_q <= sample_valid_i;
      end
   end

   assign mag_o       = mag_q;
   assign mag_valid_o = valid_q;

endmodule : adc_magnitude
`default_nettype wire

// File: rtl/acoustic_level_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : acoustic_level_meter                                          |
// | Purpose  : Windowed mean/peak magnitude meter with event detect, hold    |
// |            time and a 7-segment thermometer LED bar.                     |
// | Ports    : CLOCK, RESET - clock, synchronous active-high reset           |
// |            bus (slave)  - SAMPLE/SAMPLE_VALID/THRESHOLD in;              |
// |                           LEVEL/PEAK/LEVEL_VALID/DETECT/LED out          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module acoustic_level_meter
   import acoustic_pkg::*;
#(
   parameter int WINDOW_LOG2  = 8,
   parameter int HOLD_WINDOWS = 4
)(
   input  wire logic              CLOCK,
   input  wire logic              RESET,
   acoustic_level_meter_if.slave  bus
);

   localparam int ACC_W = ADC_WIDTH + WINDOW_LOG2;

   logic [ADC_WIDTH-1:0]   w_mag;
   logic                   w_mag_valid;
   logic [ACC_W-1:0]       w_mag_ext;
   logic                   w_close;
   logic [ADC_WIDTH-1:0]   w_level_new;

   state_t                 state_q, state_d;
   logic [ACC_W-1:0]       acc_q, acc_d;
   logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
   logic [ADC_WIDTH-1:0]   max_q, max_d;
   logic [7:0]             hold_q, hold_d;
   logic [ADC_WIDTH-1:0]   level_q, level_d;
   logic [ADC_WIDTH-1:0]   peak_q, peak_d;
   logic [LED_WIDTH-1:0]   led_q, led_d;
   logic                   detect_q, detect_d;
   logic                   level_valid_q;

   adc_magnitude u_adc_magnitude (
      .CLOCK          (CLOCK),
      .RESET          (RESET),
      .sample_i       (bus.SAMPLE),
      .sample_valid_i (bus.SAMPLE_VALID),
      .mag_o          (w_mag),
      .mag_valid_o    (w_mag_valid)
   );

   assign w_mag_ext = {{WINDOW_LOG2{1'b0}}, w_mag};

   // Window accumulation FSM. The window closes in the cycle its last
   // stage-1 sample is accumulated; results are registered on that edge so
   // they are visible, with LEVEL_VALID, during the PUBLISH cycle.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      w_close = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_mag_valid) begin
               acc_d   = w_mag_ext;
               max_d   = w_mag;
               cnt_d   = WINDOW_LOG2'(1);
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (w_mag_valid) begin
               acc_d = acc_q + w_mag_ext;
               if (w_mag > max_q) max_d = w_mag;
               cnt_d = cnt_q + WINDOW_LOG2'(1);   // wraps to 0 at window end
               if (cnt_q == {WINDOW_LOG2{1'b1}}) begin
                  w_close = 1'b1;
                  state_d = ST_PUBLISH;
               end
            end
         end
         ST_PUBLISH: begin
            state_d = ST_ACCUM;
            // A sample arriving now opens the next window instead of being lost.
            if (w_mag_valid) begin
               acc_d = w_mag_ext;
               max_d = w_mag;
               cnt_d = WINDOW_LOG2'(1);
            end else begin
               acc_d = '0;
               max_d = '0;
               cnt_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Full window sum shifted right by WINDOW_LOG2; the sum never exceeds
   // 2048 * 2^WINDOW_LOG2, so the upper ADC_WIDTH bits hold the mean exactly.
   assign w_level_new = acc_d[WINDOW_LOG2 +: ADC_WIDTH];

   always_comb begin
      level_d  = level_q;
      peak_d   = peak_q;
      led_d    = led_q;
      hold_d   = hold_q;
      detect_d = detect_q;
      if (w_close) begin
         level_d = w_level_new;
         peak_d  = max_d;
         for (int k = 0; k < LED_WIDTH; k++) begin
            led_d[k] = (w_level_new >= ADC_WIDTH'(LED_STEP * (k + 1)));
         end
         // THRESHOLD = 0 always satisfies >=, so detect sticks after a publish.
         if (w_level_new >= bus.THRESHOLD) begin
            hold_d = 8'(HOLD_WINDOWS);
         end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
         end
         detect_d = (hold_d != 8'd0);
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q       <= ST_IDLE;
         acc_q         <= '0;
         cnt_q         <= '0;
         max_q         <= '0;
         hold_q        <= '0;
         level_q       <= '0;
         peak_q        <= '0;
         led_q         <= '0;
         detect_q      <= 1'b0;
         level_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         max_q         <= max_d;
         hold_q        <= hold_d;
         level_q       <= level_d;
         peak_q        <= peak_d;
         led_q         <= led_d;
         detect_q      <= detect_d;
         level_valid_q <= w_close;
      end
   end

   assign bus.LEVEL       = level_q;
   assign bus.PEAK        = peak_q;
   assign bus.LED         = led_q;
   assign bus.DETECT      = detect_q;
   assign bus.LEVEL_VALID = level_valid_q;

endmodule : acoustic_level_meter
`default_nettype wire

// File: tb/tb_acoustic_level_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_acoustic_level_meter                                       |
// | Purpose  : Scoreboard bench for acoustic_level_meter (WINDOW_LOG2 = 2,   |
// |            HOLD_WINDOWS = 2) with directed, hand-computed vectors.       |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_acoustic_level_meter;
   import acoustic_pkg::*;

   localparam int W = 2;
   localparam int H = 2;

   typedef struct {
      logic [11:0] level;
      logic [11:0] peak;
      logic [6:0]  led;
      logic        detect;
      int          cyc;
   } exp_t;

   logic CLOCK = 1'b0;
   logic RESET;
   always #5 CLOCK = ~CLOCK;

   acoustic_level_meter_if bus ();

   acoustic_level_meter #(
      .WINDOW_LOG2  (W),
      .HOLD_WINDOWS (H)
   ) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_pub = 0;
   int   last_cyc = 0;
   exp_t sb[$];

   always @(posedge CLOCK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic drive(input logic [11:0] s, input logic v);
      @(posedge CLOCK);
      #1;
      RESET            = 1'b0;
      bus.SAMPLE       = s;
      bus.SAMPLE_VALID = v;
      if (v) last_cyc = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(12'd0, 1'b0);
   endtask

   // Expected publish is two cycles after the drive cycle of the last sample.
   task automatic expect_pub(input logic [11:0] lv, input logic [11:0] pk,
                             input logic [6:0] led, input logic det);
      exp_t e;
      e.level = lv; e.peak = pk; e.led = led; e.detect = det; e.cyc = last_cyc + 2;
      sb.push_back(e);
   endtask

   // Monitor: pops one expectation per LEVEL_VALID pulse.
   always @(negedge CLOCK) begin
      if (bus.LEVEL_VALID === 1'b1) begin
         n_pub++;
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_publish: got LEVEL_VALID=1 expected 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pub_cycle", cyc,        e.cyc);
            check("level",     bus.LEVEL,  e.level);
            check("peak",      bus.PEAK,   e.peak);
            check("led",       bus.LED,    e.led);
            check("detect",    bus.DETECT, e.detect);
         end
      end
   end

   initial begin
      RESET            = 1'b1;
      bus.SAMPLE       = 12'($urandom);
      bus.SAMPLE_VALID = 1'b1;
      bus.THRESHOLD    = 12'd4095;

      // Reset held for 3 cycles with random valid samples.
      for (int i = 0; i < 3; i++) begin
         @(posedge CLOCK);
         #1;
         bus.SAMPLE = 12'($urandom);
      end
      @(negedge CLOCK);
      check("rst_level",       bus.LEVEL,       0);
      check("rst_peak",        bus.PEAK,        0);
      check("rst_led",         bus.LED,         0);
      check("rst_detect",      bus.DETECT,      0);
      check("rst_level_valid", bus.LEVEL_VALID, 0);
      idle(3);

      // Mixed window: magnitudes 2047, 2048, 0, 1024 -> mean 1279.
      drive(12'd4095, 1'b1);
      drive(12'd0,    1'b1);
      drive(12'd2048, 1'b1);
      drive(12'd3072, 1'b1);
      expect_pub(12'd1279, 12'd2048, 7'b0001111, 1'b0);
      idle(6);

      // Continuous streaming of full-scale negative samples.
      for (int i = 0; i < 8; i++) begin
         drive(12'd0, 1'b1);
         if (i % 4 == 3) expect_pub(12'd2048, 12'd2048, 7'b1111111, 1'b0);
      end
      idle(6);

      // Detect with hold of two windows.
      bus.THRESHOLD = 12'd1000;
      drive(12'd4095, 1'b1);
      drive(12'd0,    1'b1);
      drive(12'd2048, 1'b1);
      drive(12'd3072, 1'b1);
      expect_pub(12'd1279, 12'd2048, 7'b0001111, 1'b1);
      for (int i = 0; i < 8; i++) begin
         drive(12'd2048, 1'b1);
         if (i == 3) expect_pub(12'd0, 12'd0, 7'b0, 1'b1);
         if (i == 7) expect_pub(12'd0, 12'd0, 7'b0, 1'b0);
      end
      idle(6);
      bus.THRESHOLD = 12'd4095;

      // Gapped input.
      for (int i = 0; i < 4; i++) begin
         drive(12'd2148, 1'b1);
         drive(12'd0,    1'b0);
      end
      expect_pub(12'd100, 12'd100, 7'b0, 1'b0);
      idle(6);

      // Mid-window reset discards the partial window.
      drive(12'd0, 1'b1);
      drive(12'd0, 1'b1);
      @(posedge CLOCK);
      #1;
      RESET            = 1'b1;
      bus.SAMPLE_VALID = 1'b0;
      for (int i = 0; i < 4; i++) drive(12'd2048, 1'b1);
      expect_pub(12'd0, 12'd0, 7'b0, 1'b0);
      idle(6);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge CLOCK);
      @(negedge CLOCK);
      check("scoreboard_empty", sb.size(), 0);
      check("publish_count",    n_pub,     8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_acoustic_level_meter
`default_nettype wire
